// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The entry PC lives beside this struct because its width follows the XLEN parameter.
package riscv_fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/riscv_fetch_queue.sv
// In-order prefetch queue: entries are allocated on issue, filled by responses in order,
// and freed from the head by decode.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    alloc_en,
  input  logic [XLEN-1:0]         alloc_pc,
  input  logic                    fill_en,
  input  logic [31:0]             fill_instr,
  input  logic                    deq_en,
  output logic [ptr_w(DEPTH):0]   occ,
  output logic                    head_valid,
  output logic [XLEN-1:0]         head_pc,
  output logic [31:0]             head_instr
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);

  fetch_entry_t    entry_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [PTR_W-1:0] alloc_q, fill_q, head_q;
  logic [PTR_W:0]   occ_q;
  logic             deq;

  assign occ        = occ_q;
  assign head_valid = (occ_q != '0) && entry_q[head_q].filled;
  assign head_pc    = pc_q[head_q];
  assign head_instr = entry_q[head_q].instr;
  assign deq        = deq_en && head_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else if (flush) begin
      alloc_q <= '0;
      fill_q  <= '0;
      head_q  <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i].filled <= 1'b0;
      end
    end else begin
      // Alloc, fill and head slots never coincide while the credit check holds.
      if (alloc_en) begin
        entry_q[alloc_q].filled <= 1'b0;
        pc_q[alloc_q]           <= alloc_pc;
        alloc_q                 <= alloc_q + 1'b1;
      end
      if (fill_en) begin
        entry_q[fill_q].instr  <= fill_instr;
        entry_q[fill_q].filled <= 1'b1;
        fill_q                 <= fill_q + 1'b1;
      end
      if (deq) begin
        head_q <= head_q + 1'b1;
      end
      occ_q <= occ_q + (PTR_W+1)'(alloc_en) - (PTR_W+1)'(deq);
    end
  end

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction-fetch front end: issues word fetches under a credit limit, discards stale
// responses after a redirect and hands {PC, instr} pairs to decode.
module riscv_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            decode_ready,
  output logic [31:0]     instrF,
  output logic [XLEN-1:0] PCF
);

  localparam int unsigned PTR_W = ptr_w(DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(DEPTH);

  logic [XLEN-1:0]  fetch_pc_q;
  logic [PTR_W:0]   drop_cnt_q;
  logic [PTR_W:0]   outstanding_q;
  logic [PTR_W:0]   occ;
  logic [PTR_W+1:0] used;
  logic             accept, rsp_drop, fill_en, deq_en, head_valid;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      head_instr;
  logic             unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  // Stale in-flight responses still hold a credit until they come back.
  assign used           = {1'b0, occ} + {1'b0, drop_cnt_q};
  assign imem_req_valid = reset && !redirect && (used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt_q != '0);
  assign fill_en        = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
  assign fetch_valid    = head_valid;
  assign deq_en         = head_valid && decode_ready && !redirect;
  assign instrF         = fetch_valid ? head_instr : NOP_INSTR;
  assign PCF            = fetch_valid ? head_pc : '0;

  fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect),
    .alloc_en   (accept),
    .alloc_pc   (fetch_pc_q),
    .fill_en    (fill_en),
    .fill_instr (imem_rsp_data),
    .deq_en     (deq_en),
    .occ        (occ),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_instr (head_instr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      drop_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_q + (PTR_W+1)'(accept) - (PTR_W+1)'(imem_rsp_valid);
      if (redirect) begin
        fetch_pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        // A response arriving now is discarded too, so it leaves the drop count.
        drop_cnt_q <= outstanding_q - (PTR_W+1)'(imem_rsp_valid);
      end else begin
        if (accept) begin
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
        if (rsp_drop) begin
          drop_cnt_q <= drop_cnt_q - 1'b1;
        end
      end
    end
  end

  rsp_needs_request: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: in-order memory model plus a queue-level reference model.
module tb_riscv_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h100;
  localparam logic [31:0] NOP      = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fetch_valid, decode_ready = 1'b0;
  logic [31:0] instrF, PCF;

  riscv_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .decode_ready   (decode_ready),
    .instrF         (instrF),
    .PCF            (PCF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          filled;
  } m_ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  m_ent_t      m_q[$];
  int          m_drop;
  logic [31:0] m_pc;
  mreq_t       mq[$];
  logic [31:0] cons[$];
  int          cyc, lat, n_acc, first_acc, first_fv;
  bit          rand_lat;
  int          n_assert, n_fail;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drives one cycle of inputs, checks, then advances to the next negedge.
  task automatic step(input bit rdy, input bit dec, input bit redir, input logic [31:0] rpc);
    bit          exp_rv, exp_fv, acc;
    logic [31:0] exp_pc;
    int          unf;
    imem_req_ready = rdy;
    decode_ready   = dec;
    redirect       = redir;
    redirect_pc    = rpc;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
    end
    #1;
    exp_rv = !redir && (m_q.size() + m_drop < DEPTH);
    exp_fv = (m_q.size() > 0) && m_q[0].filled;
    exp_pc = exp_fv ? m_q[0].pc : 32'h0;
    check("req_valid", 32'(imem_req_valid), 32'(exp_rv));
    check("req_addr", imem_req_addr, m_pc);
    check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
    check("PCF", PCF, exp_pc);
    check("instrF", instrF, exp_fv ? mem_data(exp_pc) : NOP);

    acc = imem_req_valid && imem_req_ready;
    if (acc) begin
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (fetch_valid && first_fv < 0) first_fv = cyc;
    if (!redir && fetch_valid && dec) cons.push_back(PCF);

    if (redir) begin
      unf = 0;
      foreach (m_q[i]) if (!m_q[i].filled) unf++;
      m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      if (exp_fv && dec) void'(m_q.pop_front());
      if (imem_rsp_valid) begin
        if (m_drop > 0) m_drop--;
        else begin
          for (int i = 0; i < m_q.size(); i++) begin
            if (!m_q[i].filled) begin
              m_q[i].filled = 1'b1;
              break;
            end
          end
        end
      end
      if (exp_rv && rdy) begin
        m_q.push_back('{pc: m_pc, filled: 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end

    if (imem_rsp_valid) void'(mq.pop_front());
    if (acc) mq.push_back('{addr: imem_req_addr,
                            due: cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat)});
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Entered at a negedge; asserts reset asynchronously mid-cycle and releases at a negedge.
  task automatic do_reset();
    #3;
    reset          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect       = 1'b0;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_fetch_valid", 32'(fetch_valid), 32'h0);
    check("rst_instrF", instrF, NOP);
    check("rst_PCF", PCF, 32'h0);
    mq.delete();
    m_q.delete();
    cons.delete();
    m_drop    = 0;
    m_pc      = RESET_PC;
    n_acc     = 0;
    first_acc = -1;
    first_fv  = -1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    lat      = 1;
    rand_lat = 1'b0;
    @(negedge clk);

    // Streaming with 1-cycle memory: one instruction per cycle, two cycles after first accept.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("first_latency", 32'(first_fv - first_acc), 32'd2);
    check("stream_pc0", cons[0], 32'h100);
    check("stream_pc1", cons[1], 32'h104);
    check("stream_pc2", cons[2], 32'h108);
    check("stream_count", 32'(cons.size()), 32'd10);

    // Decode stalled: the queue fills to DEPTH and issue stops.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    check("stall_issued", 32'(n_acc), 32'd4);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) check("drain_pc", cons[i], 32'h100 + 32'(4 * i));

    // Latency 3, two requests in flight, redirect to an unaligned target.
    do_reset();
    lat = 3;
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h2003);
    check("redir_drop", 32'(dut.drop_cnt_q), 32'd2);
    cons.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("redir_first_pc", cons[0], 32'h2000);
    check("redir_second_pc", cons[1], 32'h2004);

    // Redirect coinciding with a response and a dequeue.
    do_reset();
    lat = 2;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h3000);
    check("coinc_occ", 32'(dut.occ), 32'd0);
    check("coinc_drop", 32'(dut.drop_cnt_q), 32'd1);
    check("coinc_drop_model", 32'(dut.drop_cnt_q), 32'(m_drop));
    cons.delete();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("coinc_first_pc", cons[0], 32'h3000);

    // Random ready/decode/latency with occasional redirects.
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit          rd;
      logic [31:0] tgt;
      rd  = ($urandom_range(0, 11) == 0);
      tgt = $urandom() & 32'h0000_FFFF;
      step(bit'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, rd, tgt);
    end

    // Reset pulsed mid-stream; fetch restarts at RESET_PC.
    do_reset();
    rand_lat = 1'b0;
    lat      = 1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    check("restart_pc", cons[0], RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
